// File: rtl/expr_vector_driver_if.sv
// rtl/expr_vector_driver_if.sv - operand/result bundle between the vector driver and an expression DUT
interface expr_vector_driver_if;
    logic               start;
    logic        [3:0]  a0;
    logic        [4:0]  a1;
    logic        [5:0]  a2;
    logic signed [3:0]  a3;
    logic signed [4:0]  a4;
    logic signed [5:0]  a5;
    logic        [3:0]  b0;
    logic        [4:0]  b1;
    logic        [5:0]  b2;
    logic signed [3:0]  b3;
    logic signed [4:0]  b4;
    logic signed [5:0]  b5;
    logic        [89:0] y_in;
    logic               busy;
    logic               done;
    logic        [15:0] vec_count;
    logic        [31:0] signature;

    modport master (
        input  start, y_in,
        output a0, a1, a2, a3, a4, a5,
        output b0, b1, b2, b3, b4, b5,
        output busy, done, vec_count, signature
    );

    modport slave (
        output start, y_in,
        input  a0, a1, a2, a3, a4, a5,
        input  b0, b1, b2, b3, b4, b5,
        input  busy, done, vec_count, signature
    );
endinterface

// File: rtl/expr_vector_driver.sv
// rtl/expr_vector_driver.sv - LFSR operand generator with MISR signature over the DUT result
module expr_vector_driver #(
    parameter int          NUM_VECTORS = 256,
    parameter logic [59:0] SEED        = 60'h0ABCDEF01,
    parameter int          LAT         = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    expr_vector_driver_if.master  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [59:0] SEED_EFF   = (SEED == 60'h0) ? 60'h1 : SEED;
    localparam logic [15:0] LAST_VEC   = 16'(NUM_VECTORS - 1);
    localparam logic [2:0]  LAST_DRAIN = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

    state_t       state_q, state_d;
    logic [59:0]  lfsr_q, lfsr_d;
    logic [31:0]  sig_q, sig_d;
    logic [15:0]  vec_count_q, vec_count_d;
    logic [2:0]   drain_q, drain_d;
    logic         issue;
    logic         cap;
    logic [31:0]  fold;
    logic [31:0]  misr_next;
    logic [59:0]  lfsr_next;

    assign issue = (state_q == S_RUN);

    generate
        if (LAT == 0) begin : g_cap_comb
            assign cap = issue;
        end else begin : g_cap_pipe
            logic [LAT-1:0] cap_pipe_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    cap_pipe_q <= '0;
                end else begin
                    cap_pipe_q <= (cap_pipe_q << 1) | LAT'(issue);
                end
            end
            assign cap = cap_pipe_q[LAT-1];
        end
    endgenerate

    assign fold      = bus.y_in[31:0] ^ bus.y_in[63:32] ^ {6'b0, bus.y_in[89:64]};
    assign misr_next = {sig_q[30:0], sig_q[31] ^ sig_q[21] ^ sig_q[1] ^ sig_q[0]} ^ fold;
    assign lfsr_next = {lfsr_q[58:0], lfsr_q[59] ^ lfsr_q[58]};

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        sig_d       = sig_q;
        vec_count_d = vec_count_q;
        drain_d     = drain_q;

        // Captures lag issues by LAT cycles, so the MISR keeps absorbing in DRAIN.
        if (cap) begin
            sig_d = misr_next;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    lfsr_d      = SEED_EFF;
                    sig_d       = 32'h0;
                    vec_count_d = 16'h0;
                    drain_d     = 3'd0;
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                lfsr_d      = lfsr_next;
                vec_count_d = vec_count_q + 16'd1;
                if (vec_count_q == LAST_VEC) begin
                    drain_d = 3'd0;
                    state_d = (LAT > 0) ? S_DRAIN : S_DONE;
                end
            end
            S_DRAIN: begin
                drain_d = drain_q + 3'd1;
                if (drain_q == LAST_DRAIN) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            lfsr_q      <= SEED_EFF;
            sig_q       <= 32'h0;
            vec_count_q <= 16'h0;
            drain_q     <= 3'd0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            sig_q       <= sig_d;
            vec_count_q <= vec_count_d;
            drain_q     <= drain_d;
        end
    end

    assign bus.a0 = lfsr_q[59:56];
    assign bus.a1 = lfsr_q[55:51];
    assign bus.a2 = lfsr_q[50:45];
    assign bus.a3 = lfsr_q[44:41];
    assign bus.a4 = lfsr_q[40:36];
    assign bus.a5 = lfsr_q[35:30];
    assign bus.b0 = lfsr_q[29:26];
    assign bus.b1 = lfsr_q[25:21];
    assign bus.b2 = lfsr_q[20:15];
    assign bus.b3 = lfsr_q[14:11];
    assign bus.b4 = lfsr_q[10:6];
    assign bus.b5 = lfsr_q[5:0];

    assign bus.busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign bus.done      = (state_q == S_DONE);
    assign bus.vec_count = vec_count_q;
    assign bus.signature = sig_q;
endmodule
